mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
- Generates the mole sequence for the whack-a-mole game and judges each player press.
- Sits between the raw pushbuttons and the game FSM/datapath.
- Picks a pseudo-random hole with a free-running LFSR, holds the mole up for a fixed window, then emits one-cycle hit/miss pulses.
- Those pulses drive the datapath's player_signal and the hit/miss sound select; mole_id drives which mole screen the FSM/draw logic selects.

Parameters:
- WINDOW_CYCLES, 50_000_000, clocks a mole stays up (1 s at 50 MHz).
- GAP_CYCLES, 25_000_000, clocks between the end of one mole and the next.
- LFSR_SEED, 8'hA5, reset value of the LFSR; must be nonzero.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; high while the game is in play.
- btn  in  4  raw pushbuttons, active-high (already inverted from KEY); asynchronous to clk.
- mole_active  out  1  high while a mole is up.
- mole_id  out  2  hole index of the current/last mole.
- hit_pulse  out  1  one-cycle pulse: correct hole pressed in time.
- miss_pulse  out  1  one-cycle pulse: wrong hole pressed, or timeout.
- round_count  out  8  moles judged since the last enable rise; saturates at 255.

Behaviour:
- Reset (async, high): state IDLE, all outputs 0, LFSR = LFSR_SEED, sync/edge registers 0, counters 0.
- Button input: each btn bit goes through a 2-FF synchroniser, then a rising-edge detect (s2 & ~s2_d).
  - Button sampled high at clock edge E0 -> edge flag valid in the cycle after E1.
  - Result state is entered at E2; the pulse is high from E2 to E3.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every clock in every state, so the outcome depends on player timing.
  - Never reaches zero.
- FSM states: IDLE, GAP, UP, RESULT.
- IDLE: outputs 0.
  - On an enable rising edge: round_count <= 0, gap counter <= GAP_CYCLES-1, go to GAP.
- GAP: decrement the gap counter; button edges are ignored.
  - At 0: candidate = lfsr[1:0]. If candidate == previous mole_id, mole_id <= candidate+1 (mod 4); otherwise mole_id <= candidate.
  - Window counter <= WINDOW_CYCLES-1, go to UP.
  - The first mole after IDLE never uses the repeat check.
- UP: mole_active = 1; decrement the window counter each cycle.
  - Any edge on the mole_id bit only -> RESULT with hit.
  - Any edge on another bit, with or without the correct bit in the same cycle -> RESULT with miss.
  - No edge and counter == 0 -> RESULT with miss. UP therefore lasts exactly WINDOW_CYCLES cycles.
  - Edge in the same cycle as expiry: the press is judged; the timeout is ignored.
- RESULT: lasts exactly 1 cycle; mole_active = 0.
  - Exactly one of hit_pulse/miss_pulse is high.
  - round_count increments, saturating at 255.
  - Gap counter reloads; next state is GAP.
- enable low in any state: next state IDLE, mole_active drops the next cycle.
  - A pending RESULT is dropped with no pulse.
  - round_count and mole_id hold their values until the next enable rise.
- Outputs are registered or decoded directly from state registers; no combinational path from btn to any output.
- Counter widths: clog2 of the corresponding parameter; no wrap beyond the load value.

Decomposition:
- Shared package whack_pkg:
  - state encoding constants (IDLE=2'd0, GAP=2'd1, UP=2'd2, RESULT=2'd3)
  - NUM_HOLES=4
  - MOLE_ID_W=2
  - LFSR tap mask
- One sub-module, btn_edge_sync: per-bit 2-FF synchroniser plus rising-edge detect, instantiated with width 4.
- LFSR and FSM live in mole_scheduler.

Test Plan:
- Bench params for all cases: WINDOW_CYCLES=8, GAP_CYCLES=4.
- Reset mid-run: with enable high, assert reset during UP -> all outputs 0 immediately; after release, state IDLE; LFSR reloads 8'hA5.
- Timeout path: raise enable, no buttons:
  - first mole_active rises 5 cycles after the enable edge and is high exactly 8 cycles;
  - miss_pulse is high 1 cycle; round_count=1;
  - next mole_active rises 5 cycles after RESULT.
- Correct hit: during UP, hold btn[mole_id] high for 3 cycles -> hit_pulse rises at E2 after the first sampling edge, 1 cycle wide; only one pulse per press; miss_pulse stays 0.
- Wrong/simultaneous press: during UP, raise btn[mole_id] and another btn in the same cycle -> miss_pulse only. Separately, a press during GAP -> no pulse, and the mole still appears.
- Boundary and saturation:
  - press edge lands on the expiry cycle -> hit_pulse, not miss;
  - run 300 rounds -> round_count holds 255;
  - consecutive mole_id values are never equal across 300 rounds;
  - dropping enable during RESULT -> no pulse, IDLE next cycle.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared constants, state encoding and LFSR helper for the whack-a-mole game.
package whack_pkg;

  localparam int unsigned NUM_HOLES = 4;
  localparam int unsigned MOLE_ID_W = 2;
  localparam int unsigned LFSR_W    = 8;
  localparam int unsigned ROUND_W   = 8;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_UP     = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  // One Fibonacci step: shift left, feed back the parity of the tapped bits
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Per-bit two-flop synchroniser followed by a rising-edge detector.
module btn_edge_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s2_d;

  // Synchroniser stages plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      s2_d <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign rise_c = s2 & ~s2_d;

endmodule

// File: rtl/mole_scheduler.sv
// Mole sequencer: picks holes from a free-running LFSR, times the mole window
// and judges player presses into single-cycle hit/miss pulses.
module mole_scheduler
  import whack_pkg::*;
#(
  parameter int unsigned        WINDOW_CYCLES = 50_000_000,
  parameter int unsigned        GAP_CYCLES    = 25_000_000,
  parameter logic [LFSR_W-1:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_HOLES-1:0]  btn,
  output logic                  mole_active,
  output logic [MOLE_ID_W-1:0]  mole_id,
  output logic                  hit_pulse,
  output logic                  miss_pulse,
  output logic [ROUND_W-1:0]    round_count
);

  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [MOLE_ID_W-1:0] id_q, id_d;
  logic [ROUND_W-1:0]   rc_q, rc_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 first_q, first_d;
  logic                 enable_q;

  logic [NUM_HOLES-1:0] edges_c;
  logic [NUM_HOLES-1:0] hole_mask_c;
  logic                 press_c;
  logic                 wrong_c;
  logic [MOLE_ID_W-1:0] cand_c;
  logic [ROUND_W-1:0]   rc_inc_c;

  btn_edge_sync #(.W(NUM_HOLES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (btn),
    .rise_c (edges_c)
  );

  assign hole_mask_c = NUM_HOLES'(1) << id_q;
  assign press_c     = |edges_c;
  assign wrong_c     = |(edges_c & ~hole_mask_c);
  assign cand_c      = lfsr_q[MOLE_ID_W-1:0];
  assign rc_inc_c    = (rc_q == '1) ? rc_q : rc_q + ROUND_W'(1);

  // State, LFSR, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED;
      gap_q    <= '0;
      win_q    <= '0;
      id_q     <= '0;
      rc_q     <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      first_q  <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      gap_q    <= gap_d;
      win_q    <= win_d;
      id_q     <= id_d;
      rc_q     <= rc_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      first_q  <= first_d;
      enable_q <= enable;
    end
  end

  // Next-state and next-value logic; enable low overrides every transition
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_next(lfsr_q);
    gap_d   = gap_q;
    win_d   = win_q;
    id_d    = id_q;
    rc_d    = rc_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    first_d = first_q;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!enable_q) begin
            rc_d    = '0;
            gap_d   = GAP_LOAD;
            first_d = 1'b1;
            state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            // Avoid showing the same hole twice in a row, except right after start
            if (!first_q && (cand_c == id_q)) begin
              id_d = cand_c + MOLE_ID_W'(1);
            end else begin
              id_d = cand_c;
            end
            first_d = 1'b0;
            win_d   = WIN_LOAD;
            state_d = ST_UP;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        ST_UP: begin
          // A press is judged even on the last window cycle
          if (press_c) begin
            hit_d   = ~wrong_c;
            miss_d  = wrong_c;
            rc_d    = rc_inc_c;
            state_d = ST_RESULT;
          end else if (win_q == '0) begin
            miss_d  = 1'b1;
            rc_d    = rc_inc_c;
            state_d = ST_RESULT;
          end else begin
            win_d = win_q - WIN_W'(1);
          end
        end
        ST_RESULT: begin
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      endcase
    end
  end

  assign mole_active = (state_q == ST_UP);
  assign mole_id     = id_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;
  assign round_count = rc_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler with short window/gap timing.
module tb_mole_scheduler;

  localparam int unsigned WIN = 8;
  localparam int unsigned GAP = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] btn    = 4'h0;
  logic       mole_active;
  logic [1:0] mole_id;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] round_count;

  mole_scheduler #(
    .WINDOW_CYCLES (WIN),
    .GAP_CYCLES    (GAP),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .btn         (btn),
    .mole_active (mole_active),
    .mole_id     (mole_id),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .round_count (round_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: x^8+x^6+x^5+x^4, shifted left, seeded on reset
  logic [7:0] m_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct {
    bit hit;
    int due;
  } sb_t;

  // mode: 0 none, 1 correct hole, 2 correct plus neighbour, 3 neighbour only
  typedef struct {
    string name;
    int    mode;
    int    offset;
    int    hold;
    bit    exp_hit;
    int    exp_due;
  } vec_t;

  sb_t        sb[$];
  vec_t       vecs[8];
  int         total = 0;
  int         bad   = 0;
  bit         prev_active = 1'b0;
  bit         pulse_prev  = 1'b0;
  bit         m_first     = 1'b1;
  bit         rose        = 1'b0;
  bit         exp_rise_v  = 1'b0;
  int         exp_rise    = 0;
  int         up_start    = 0;
  int         m_rc        = 0;
  logic [7:0] prev_lfsr   = 8'h00;
  logic [1:0] m_last      = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and run the output monitor there
  task automatic step();
    sb_t        e;
    logic [1:0] cand;
    @(negedge clk);
    if (reset) begin
      prev_active = 1'b0;
      pulse_prev  = 1'b0;
      prev_lfsr   = m_lfsr;
      return;
    end
    if (hit_pulse || miss_pulse) begin
      chk("one_hot_pulse", 32'(hit_pulse) + 32'(miss_pulse), 1);
      chk("pulse_single", pulse_prev, 0);
      chk("active_in_result", mole_active, 0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: actual hit=%0d miss=%0d required no pulse (cycle %0d)",
                 hit_pulse, miss_pulse, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_is_hit", hit_pulse, e.hit);
        chk("pulse_cycle", cyc, e.due);
        m_rc = (m_rc >= 255) ? 255 : m_rc + 1;
        chk("round_count", round_count, m_rc);
      end
      exp_rise   = cyc + GAP + 1;
      exp_rise_v = 1'b1;
    end
    if (mole_active && !prev_active) begin
      cand = prev_lfsr[1:0];
      if (!m_first && cand == m_last) cand = cand + 2'd1;
      chk("mole_id", mole_id, cand);
      if (!m_first) chk("no_repeat", 32'(mole_id != m_last), 1);
      if (exp_rise_v) chk("rise_cycle", cyc, exp_rise);
      exp_rise_v = 1'b0;
      m_last     = cand;
      m_first    = 1'b0;
      rose       = 1'b1;
      up_start   = cyc;
    end
    pulse_prev  = hit_pulse || miss_pulse;
    prev_active = mole_active;
    prev_lfsr   = m_lfsr;
  endtask

  task automatic start_game();
    enable     = 1'b1;
    m_first    = 1'b1;
    m_rc       = 0;
    exp_rise   = cyc + GAP + 1;
    exp_rise_v = 1'b1;
  endtask

  task automatic wait_rise(output bit ok);
    rose = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (rose) begin
        ok = 1'b1;
        return;
      end
    end
    ok = 1'b0;
    total++;
    bad++;
    $display("FAIL wait_rise: actual no mole within 60 cycles required a mole");
  endtask

  task automatic run_vec(input vec_t v);
    bit         ok;
    sb_t        e;
    logic [3:0] pv;
    logic [1:0] nb;
    wait_rise(ok);
    if (!ok) return;
    e.hit = v.exp_hit;
    e.due = up_start + v.exp_due;
    sb.push_back(e);
    nb = m_last + 2'd1;
    case (v.mode)
      1:       pv = 4'(1) << m_last;
      2:       pv = (4'(1) << m_last) | (4'(1) << nb);
      3:       pv = 4'(1) << nb;
      default: pv = 4'h0;
    endcase
    for (int k = 0; k < 40; k++) begin
      if (v.mode != 0 && k == v.offset) btn = pv;
      if (k == v.offset + v.hold) btn = 4'h0;
      if (k >= v.offset + v.hold && sb.size() == 0) break;
      step();
    end
    btn = 4'h0;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pulse_timeout %s: actual no pulse required one", v.name);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    int         rc_hold;
    logic [1:0] id_hold;

    vecs[0] = '{"timeout",        0, 0, 0, 1'b0, 8};
    vecs[1] = '{"hit_hold3",      1, 0, 3, 1'b1, 3};
    vecs[2] = '{"hit_mid",        1, 2, 1, 1'b1, 5};
    vecs[3] = '{"both_bits",      2, 1, 2, 1'b0, 4};
    vecs[4] = '{"wrong_only",     3, 0, 1, 1'b0, 3};
    vecs[5] = '{"hit_on_expiry",  1, 5, 2, 1'b1, 8};
    vecs[6] = '{"late_press",     1, 6, 1, 1'b0, 8};
    vecs[7] = '{"hit_d3_hold3",   1, 3, 3, 1'b1, 6};

    // Reset values, then idle with enable low
    step();
    chk("rst_active", mole_active, 0);
    chk("rst_id", mole_id, 0);
    chk("rst_hit", hit_pulse, 0);
    chk("rst_miss", miss_pulse, 0);
    chk("rst_round", round_count, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_no_enable", mole_active, 0);
    end

    // Table of press scenarios within one game
    start_game();
    foreach (vecs[i]) run_vec(vecs[i]);

    // Press during the gap is ignored and the mole still appears
    run_vec(vecs[0]);
    step();
    btn = 4'hF;
    step();
    btn = 4'h0;
    run_vec(vecs[0]);

    // Drop enable while a judged press is pending
    wait_rise(ok);
    if (ok) begin
      btn = 4'(1) << m_last;
      step();
      step();
      enable     = 1'b0;
      exp_rise_v = 1'b0;
      rc_hold    = m_rc;
      id_hold    = m_last;
      step();
      btn = 4'h0;
      chk("idle_after_drop", mole_active, 0);
      for (int i = 0; i < 8; i++) begin
        step();
        chk("stay_idle", mole_active, 0);
      end
      chk("round_held", round_count, rc_hold);
      chk("id_held", mole_id, id_hold);
    end

    // Asynchronous reset while a mole is up
    start_game();
    wait_rise(ok);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("async_active", mole_active, 0);
    chk("async_id", mole_id, 0);
    chk("async_hit", hit_pulse, 0);
    chk("async_miss", miss_pulse, 0);
    chk("async_round", round_count, 0);
    sb.delete();
    step();
    reset      = 1'b0;
    m_first    = 1'b1;
    m_rc       = 0;
    exp_rise   = cyc + GAP + 1;
    exp_rise_v = 1'b1;
    #1;
    chk("post_rst_active", mole_active, 0);
    chk("post_rst_round", round_count, 0);
    run_vec(vecs[0]);

    // Saturation and no-repeat over many timeouts from a fresh start
    enable     = 1'b0;
    exp_rise_v = 1'b0;
    step();
    start_game();
    for (int r = 0; r < 300; r++) run_vec(vecs[0]);
    chk("round_saturated", round_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
